ifetch_ctrl: RTL
================

# ifetch_ctrl

Instruction-fetch sequencer for the pipelined MIPS core. Owns the program counter, drives the address of the combinational instruction memory, and registers the returned word into the IF/ID stage register. Applies stall, flush and branch/jump redirect requests from the later pipeline stages. Detects the end of the program image, drains the pipeline with NOPs and reports halt.

## Interface
- `IMEM_BYTES`, default 60: byte limit of the program image; fetch addresses at or above it end the program.
- `RESET_PC`, default 0: start address; must be word-aligned.
- `DRAIN_CYCLES`, default 4: NOP cycles issued after end of program before halt; range 1..15.
- `clk` in 1: clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: starts fetching at `RESET_PC`; sampled in IDLE and HALT only.
- `stall` in 1: holds the PC and IF/ID.
- `flush` in 1: squashes the word being fetched this cycle.
- `redirect` in 1: taken branch or jump.
- `redirect_pc` in 32: redirect target; bits [1:0] are ignored and treated as 0.
- `imem_addr` out 32: instruction-memory address; equals the PC register.
- `imem_data` in 32: instruction-memory read data (combinational).
- `ifid_instr` out 32: IF/ID instruction.
- `ifid_pc4` out 32: IF/ID PC+4.
- `ifid_valid` out 1: IF/ID holds a real instruction.
- `busy` out 1: high in RUN and DRAIN.
- `halted` out 1: high in HALT.

## Operation
- States: IDLE, RUN, DRAIN, HALT.
- **Reset values:**
  - State IDLE; `pc` = `RESET_PC`.
  - `ifid_instr` = 0 (NOP), `ifid_pc4` = 0, `ifid_valid` = 0.
  - `busy` = 0, `halted` = 0.
- **IDLE:** IF/ID holds NOP with `ifid_valid` = 0. `start` loads `pc` = `RESET_PC` and moves to RUN.
- **RUN:** the first matching rule applies each cycle.
  1. `redirect`: `pc` ← `{redirect_pc[31:2], 2'b00}`; IF/ID ← NOP, `ifid_valid` = 0. This applies even when `stall` or `flush` is also high.
  2. `flush`: IF/ID ← NOP, `ifid_valid` = 0; `pc` ← `pc`+4. This applies even when `stall` is also high.
  3. `stall`: `pc` and IF/ID unchanged.
  4. `pc` ≥ `IMEM_BYTES`: IF/ID ← NOP, `ifid_valid` = 0; `pc` unchanged; drain counter ← `DRAIN_CYCLES`−1; go to DRAIN.
  5. Otherwise: `ifid_instr` ← `imem_data`, `ifid_pc4` ← `pc`+4, `ifid_valid` = 1, `pc` ← `pc`+4.
- **DRAIN:**
  - IF/ID is forced to NOP with `ifid_valid` = 0.
  - The drain counter decrements each cycle that `stall` is low and holds while `stall` is high.
  - When the counter is 0 and `stall` is low, go to HALT.
  - `redirect` to a target below `IMEM_BYTES`: load `pc` and return to RUN. A redirect target at or above `IMEM_BYTES` is ignored.
- **HALT:** all outputs hold; IF/ID holds NOP. `start` restarts exactly as from IDLE.
- **Arithmetic:** `pc`+4 wraps modulo 2^32. The limit compare is unsigned on the full 32 bits.
- **Mid-operation reset:** `reset` takes effect immediately, regardless of state or pending requests.

## Timing
- The word at `imem_addr` = A is captured on the edge that accepts it. `ifid_instr` shows it in the following cycle, a latency of 1 cycle.
- **Redirect penalty:** one bubble. The target instruction appears in IF/ID 2 cycles after `redirect` is sampled.
- **Stall:** zero-cycle response; the edge on which `stall` is sampled high changes nothing.
- **Halt timing:** the last valid instruction leaves IF/ID when DRAIN is entered. `halted` rises `DRAIN_CYCLES` cycles later, when no stall occurs.
- All outputs are registered except `busy` and `halted`, which are decoded from state flops.

## Configuration
- **`IFETCH_PERF_EN` defined:** adds three 32-bit output ports, each reset to 0 and saturating at all-ones.
  - `perf_fetch`: counts cycles that load a valid word.
  - `perf_stall`: counts RUN/DRAIN cycles with `stall` applied.
  - `perf_squash`: counts redirect or flush cycles in RUN.
  - The counters clear on `start`.
- **`IFETCH_PERF_EN` undefined:** the ports and counters do not exist; behaviour is otherwise identical.

## Structure
- The shared package `mips_pkg` holds:
  - the state encoding;
  - `NOP_INSTR` = 32'h0000_0000;
  - the word-align mask;
  - the default `IMEM_BYTES`.
- The counters live in one sub-module, `ifetch_perf_cnt`, instantiated only under `IFETCH_PERF_EN`.
- PC, IF/ID and the FSM are in the top level.

## Test plan
- **Reset then start, with the 15-word program image:** the IF/ID sequence carries `ifid_pc4` = 4, 8, …, 60. `ifid_valid` is low for one cycle after start and high thereafter. Reaching `pc` = 60 enters DRAIN, and `halted` is 1 four cycles later.
- **Stall held 3 cycles while `pc` = 12:** `imem_addr` stays 12, `ifid_instr` is frozen, then fetch resumes at 12. With `IFETCH_PERF_EN`, `perf_stall` = 3.
- **`redirect` with `redirect_pc` = 32'h33 while `pc` = 24:** the next `imem_addr` = 48 and IF/ID shows NOP. The cycle after, `ifid_pc4` = 52 with `ifid_valid` = 1.
- **`redirect`, `flush` and `stall` all high in one cycle:** the redirect wins. `stall` alone on the next cycle freezes `pc` at the target.
- **In DRAIN with counter 2, `redirect_pc` = 8:** return to RUN, `imem_addr` = 8, `halted` never asserts. A redirect target of 64 instead leaves DRAIN unchanged.
- **`reset` asserted mid-RUN between clock edges:** all outputs immediately take their reset values. A later `start` refetches from 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM encoding, NOP word, alignment mask.
// No logic; constants and types only.
// Imported by ifetch_ctrl and ifetch_perf_cnt.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } if_state_t;

    localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK    = 32'hFFFF_FFFC;
    localparam int unsigned IMEM_BYTES_DEFAULT = 60;

endpackage

// File: rtl/ifetch_perf_cnt.sv
// Fetch performance counters: valid fetches, applied stalls, squashed fetch cycles.
// Latency: each count lands on the edge after its event; clr wins over increments.
// Backpressure: none; counters saturate at all-ones. Present only with IFETCH_PERF_EN.
`ifdef IFETCH_PERF_EN
module ifetch_perf_cnt
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc_fetch,
    input  logic        inc_stall,
    input  logic        inc_squash,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_squash
);

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
        return (inc && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch  <= 32'd0;
            perf_stall  <= 32'd0;
            perf_squash <= 32'd0;
        end else if (clr) begin
            perf_fetch  <= 32'd0;
            perf_stall  <= 32'd0;
            perf_squash <= 32'd0;
        end else begin
            perf_fetch  <= sat_inc(perf_fetch, inc_fetch);
            perf_stall  <= sat_inc(perf_stall, inc_stall);
            perf_squash <= sat_inc(perf_squash, inc_squash);
        end
    end

endmodule
`endif

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, registers imem words into IF/ID, drains and halts at image end.
// Latency: 1 cycle from imem_addr to ifid_instr; redirect costs one bubble.
// Backpressure: stall freezes PC and IF/ID in the same cycle; IFETCH_PERF_EN adds perf counter ports.
module ifetch_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned IMEM_BYTES   = IMEM_BYTES_DEFAULT,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        busy,
    output logic        halted
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_squash
`endif
);

    localparam logic [31:0] LIMIT      = 32'(IMEM_BYTES);
    localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    if_state_t   state;
    if_state_t   state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] tgt;
    logic [31:0] instr_nxt;
    logic [31:0] pc4_nxt;
    logic        valid_nxt;
    logic [3:0]  drain_cnt;
    logic [3:0]  cnt_nxt;
    logic        at_end;
    logic        tgt_in_image;

    assign pc_plus4     = pc + 32'd4;
    assign tgt          = redirect_pc & WORD_ALIGN_MASK;
    assign at_end       = (pc >= LIMIT);
    assign tgt_in_image = (tgt < LIMIT);

    assign imem_addr = pc;
    assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
    assign halted    = (state == ST_HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            ifid_instr <= NOP_INSTR;
            ifid_pc4   <= 32'd0;
            ifid_valid <= 1'b0;
            drain_cnt  <= 4'd0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            ifid_instr <= instr_nxt;
            ifid_pc4   <= pc4_nxt;
            ifid_valid <= valid_nxt;
            drain_cnt  <= cnt_nxt;
        end
    end

    // RUN rules are strictly prioritised: redirect, flush, stall, end-of-image, fetch.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = ifid_instr;
        pc4_nxt   = ifid_pc4;
        valid_nxt = ifid_valid;
        cnt_nxt   = drain_cnt;

        case (state)
            ST_IDLE, ST_HALT: begin
                instr_nxt = NOP_INSTR;
                valid_nxt = 1'b0;
                if (start) begin
                    pc_nxt    = RESET_PC;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_nxt    = tgt;
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                end else if (flush) begin
                    pc_nxt    = pc_plus4;
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                end else if (stall) begin
                    pc_nxt = pc;
                end else if (at_end) begin
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                    cnt_nxt   = DRAIN_LOAD;
                    state_nxt = ST_DRAIN;
                end else begin
                    instr_nxt = imem_data;
                    pc4_nxt   = pc_plus4;
                    valid_nxt = 1'b1;
                    pc_nxt    = pc_plus4;
                end
            end
            ST_DRAIN: begin
                instr_nxt = NOP_INSTR;
                valid_nxt = 1'b0;
                if (redirect && tgt_in_image) begin
                    pc_nxt    = tgt;
                    state_nxt = ST_RUN;
                end else if (!stall) begin
                    if (drain_cnt == 4'd0) begin
                        state_nxt = ST_HALT;
                    end else begin
                        cnt_nxt = drain_cnt - 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef IFETCH_PERF_EN
    logic ev_clear;
    logic ev_fetch;
    logic ev_stall;
    logic ev_squash;

    assign ev_clear  = ((state == ST_IDLE) || (state == ST_HALT)) && start;
    assign ev_squash = (state == ST_RUN) && (redirect || flush);
    assign ev_fetch  = (state == ST_RUN) && !redirect && !flush && !stall && !at_end;
    // A stall counts only when it actually held the sequencer, not when a redirect/flush overrode it.
    assign ev_stall  = stall && (((state == ST_RUN) && !redirect && !flush) ||
                                 ((state == ST_DRAIN) && !(redirect && tgt_in_image)));

    ifetch_perf_cnt u_perf (
        .clk         (clk),
        .reset       (reset),
        .clr         (ev_clear),
        .inc_fetch   (ev_fetch),
        .inc_stall   (ev_stall),
        .inc_squash  (ev_squash),
        .perf_fetch  (perf_fetch),
        .perf_stall  (perf_stall),
        .perf_squash (perf_squash)
    );
`endif

endmodule
